// File: rtl/div_ctrl_if.sv
// Request/response channel between the execute stage (master) and the
// divide controller (slave). Widths default to RV32 with 5-bit tags.
interface div_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [XLEN-1:0]  req_rs1;
  logic [XLEN-1:0]  req_rs2;
  logic [TAG_W-1:0] req_tag;
  logic             resp_valid;
  logic             resp_ready;
  logic [XLEN-1:0]  resp_data;
  logic [TAG_W-1:0] resp_tag;

  // Execute stage: issues requests, consumes responses.
  modport master (
    output req_valid, req_op, req_rs1, req_rs2, req_tag, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_tag
  );

  // Divide controller: accepts requests, produces responses.
  modport slave (
    input  req_valid, req_op, req_rs1, req_rs2, req_tag, resp_ready,
    output req_ready, resp_valid, resp_data, resp_tag
  );
endinterface

// File: rtl/div_ctrl.sv
// RV32M DIV/DIVU/REM/REMU controller in front of a sequential unsigned
// divider. Signed operands are reduced to magnitudes, the divider is started
// and waited on, then the sign is restored on the selected result.
// Divide-by-zero and signed overflow are answered without using the divider.
module div_ctrl #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  div_ctrl_if.slave       bus,
  input  logic            flush,
  output logic            div_start,
  output logic [XLEN-1:0] div_dividend,
  output logic [XLEN-1:0] div_divisor,
  input  logic [XLEN-1:0] div_quotient,
  input  logic [XLEN-1:0] div_remainder,
  input  logic            div_busy
);

  typedef enum logic [2:0] {
    IDLE, START, WAIT, FIX, RESP, DRAIN
  } state_t;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ONE     = XLEN'(1);

  state_t           r_state;
  logic             r_sel_rem;   // result is the remainder (REM/REMU)
  logic             r_neg_q;     // quotient needs negation
  logic             r_neg_r;     // remainder needs negation
  logic [XLEN-1:0]  r_dividend;
  logic [XLEN-1:0]  r_divisor;
  logic [XLEN-1:0]  r_quo;
  logic [XLEN-1:0]  r_rem;
  logic             r_resp_valid;
  logic [XLEN-1:0]  r_resp_data;
  logic [TAG_W-1:0] r_resp_tag;

  logic             w_accept;
  logic             w_signed;
  logic             w_rs1_neg;
  logic             w_rs2_neg;
  logic [XLEN-1:0]  w_mag1;
  logic [XLEN-1:0]  w_mag2;
  logic             w_div_zero;
  logic             w_overflow;
  logic [XLEN-1:0]  w_special_data;
  logic [XLEN-1:0]  w_fix_q;
  logic [XLEN-1:0]  w_fix_r;

  // NOTE: plain continuous assigns for pure combinational decode; nothing
  // here holds state, so no latch can be inferred.
  assign bus.req_ready = (r_state == IDLE) && !flush;
  assign w_accept      = bus.req_valid && bus.req_ready;

  // funct3[0]==0 selects the signed variants (DIV, REM).
  assign w_signed  = ~bus.req_op[0];
  assign w_rs1_neg = w_signed & bus.req_rs1[XLEN-1];
  assign w_rs2_neg = w_signed & bus.req_rs2[XLEN-1];
  // INT_MIN negates to itself, which is exactly its unsigned magnitude.
  assign w_mag1    = w_rs1_neg ? (~bus.req_rs1 + ONE) : bus.req_rs1;
  assign w_mag2    = w_rs2_neg ? (~bus.req_rs2 + ONE) : bus.req_rs2;

  assign w_div_zero = (bus.req_rs2 == '0);
  assign w_overflow = w_signed && (bus.req_rs1 == INT_MIN) && (bus.req_rs2 == '1);

  // Architected results for the cases the divider never sees.
  assign w_special_data = w_div_zero ? (bus.req_op[1] ? bus.req_rs1 : '1)
                                     : (bus.req_op[1] ? '0 : INT_MIN);

  assign w_fix_q = r_neg_q ? (~r_quo + ONE) : r_quo;
  assign w_fix_r = r_neg_r ? (~r_rem + ONE) : r_rem;

  // The start pulse is the START state itself; a flush in that cycle kills it.
  assign div_start      = (r_state == START) && !flush;
  // A flushed response is withdrawn in the same cycle so it cannot transfer.
  assign bus.resp_valid = r_resp_valid && !flush;
  assign bus.resp_data  = r_resp_data;
  assign bus.resp_tag   = r_resp_tag;
  assign div_dividend   = r_dividend;
  assign div_divisor    = r_divisor;

  // Control FSM and all datapath registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_sel_rem    <= 1'b0;
      r_neg_q      <= 1'b0;
      r_neg_r      <= 1'b0;
      r_dividend   <= '0;
      r_divisor    <= '0;
      r_quo        <= '0;
      r_rem        <= '0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_resp_tag   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_sel_rem  <= bus.req_op[1];
            r_neg_q    <= w_rs1_neg ^ w_rs2_neg;
            r_neg_r    <= w_rs1_neg;
            r_dividend <= w_mag1;
            r_divisor  <= w_mag2;
            r_resp_tag <= bus.req_tag;
            if (w_div_zero || w_overflow) begin
              r_resp_data  <= w_special_data;
              r_resp_valid <= 1'b1;
              r_state      <= RESP;
            end else begin
              r_state <= START;
            end
          end
        end
        START: begin
          r_state <= flush ? IDLE : WAIT;
        end
        WAIT: begin
          if (flush) begin
            r_state <= DRAIN;
          end else if (!div_busy) begin
            r_quo   <= div_quotient;
            r_rem   <= div_remainder;
            r_state <= FIX;
          end
        end
        FIX: begin
          if (flush) begin
            r_state <= IDLE;
          end else begin
            r_resp_data  <= r_sel_rem ? w_fix_r : w_fix_q;
            r_resp_valid <= 1'b1;
            r_state      <= RESP;
          end
        end
        RESP: begin
          if (flush || bus.resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= IDLE;
          end
        end
        DRAIN: begin
          // The divider finishes the killed operation; its result is dropped.
          if (!div_busy) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed testbench for div_ctrl with a behavioural 3-cycle divider.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        div_start;
  logic [31:0] div_dividend, div_divisor;
  logic [31:0] div_quotient, div_remainder;
  logic        div_busy;

  int pass_cnt = 0;
  int total_cnt = 0;
  int start_cnt = 0;
  int start_while_busy = 0;

  div_ctrl_if #(.XLEN(32), .TAG_W(5)) bus ();

  div_ctrl #(.XLEN(32), .TAG_W(5)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .flush         (flush),
    .div_start     (div_start),
    .div_dividend  (div_dividend),
    .div_divisor   (div_divisor),
    .div_quotient  (div_quotient),
    .div_remainder (div_remainder),
    .div_busy      (div_busy)
  );

  always #5 clk = ~clk;

  // Divider model: busy for 3 cycles after start, result valid when busy drops.
  logic [31:0] m_a, m_b;
  int          m_cnt;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      div_busy      <= 1'b0;
      m_cnt         <= 0;
      m_a           <= '0;
      m_b           <= '0;
      div_quotient  <= '0;
      div_remainder <= '0;
    end else if (div_start) begin
      m_a      <= div_dividend;
      m_b      <= div_divisor;
      div_busy <= 1'b1;
      m_cnt    <= 3;
    end else if (div_busy) begin
      if (m_cnt == 1) begin
        div_busy      <= 1'b0;
        div_quotient  <= m_a / m_b;
        div_remainder <= m_a % m_b;
      end
      m_cnt <= m_cnt - 1;
    end
  end

  // Start-pulse bookkeeping.
  always @(posedge clk) begin
    if (!reset && div_start) begin
      start_cnt++;
      if (div_busy) start_while_busy++;
    end
  end

  // Present a request and hold it until the accepting edge has passed.
  task automatic accept_req(input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] tag);
    int n = 0;
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_rs1   = a;
    bus.req_rs2   = b;
    bus.req_tag   = tag;
    @(negedge clk);
    while (bus.req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    total_cnt++;
    if (n >= 50) $display("FAIL accept_timeout: req_ready=%b required 1", bus.req_ready);
    else pass_cnt++;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  // Wait for resp_valid; lat counts negedges after acceptance (-1 on timeout).
  task automatic wait_resp(output int lat, output logic [31:0] d, output logic [4:0] t);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (bus.resp_valid !== 1'b1 && lat < 100);
    if (bus.resp_valid !== 1'b1) lat = -1;
    d = bus.resp_data;
    t = bus.resp_tag;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total_cnt++;
    if (bus.resp_valid !== 1'b0 || div_start !== 1'b0 || bus.resp_data !== 32'h0 ||
        bus.resp_tag !== 5'h0 || div_dividend !== 32'h0 || div_divisor !== 32'h0)
      $display("FAIL reset_outputs: valid=%b start=%b data=%h tag=%h dd=%h ds=%h required all 0",
               bus.resp_valid, div_start, bus.resp_data, bus.resp_tag, div_dividend, div_divisor);
    else pass_cnt++;
    total_cnt++;
    if (bus.req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b required 1", bus.req_ready);
    else pass_cnt++;
  endtask

  task automatic test_signed();
    int lat; logic [31:0] d; logic [4:0] t; int s0;
    s0 = start_cnt;
    accept_req(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd4);
    wait_resp(lat, d, t);
    total_cnt++;
    if (d !== 32'hFFFF_FFFD) $display("FAIL div_neg7_2: got %h required fffffffd", d);
    else pass_cnt++;
    total_cnt++;
    if (lat !== 7) $display("FAIL div_latency: got %0d required 7", lat);
    else pass_cnt++;
    total_cnt++;
    if (start_cnt - s0 !== 1) $display("FAIL div_start_count: got %0d required 1", start_cnt - s0);
    else pass_cnt++;
    total_cnt++;
    if (div_dividend !== 32'd7 || div_divisor !== 32'd2)
      $display("FAIL div_magnitudes: got %h/%h required 00000007/00000002", div_dividend, div_divisor);
    else pass_cnt++;
    accept_req(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd5);
    wait_resp(lat, d, t);
    total_cnt++;
    if (d !== 32'hFFFF_FFFF || t !== 5'd5)
      $display("FAIL rem_neg7_2: got %h tag %0d required ffffffff tag 5", d, t);
    else pass_cnt++;
  endtask

  task automatic test_unsigned();
    int lat; logic [31:0] d; logic [4:0] t;
    accept_req(2'b01, 32'hFFFF_FFFF, 32'd3, 5'd17);
    wait_resp(lat, d, t);
    total_cnt++;
    if (d !== 32'h5555_5555 || t !== 5'd17)
      $display("FAIL divu_max_3: got %h tag %0d required 55555555 tag 17", d, t);
    else pass_cnt++;
    accept_req(2'b11, 32'd100, 32'd7, 5'd17);
    wait_resp(lat, d, t);
    total_cnt++;
    if (d !== 32'd2 || t !== 5'd17)
      $display("FAIL remu_100_7: got %h tag %0d required 00000002 tag 17", d, t);
    else pass_cnt++;
  endtask

  task automatic test_special();
    int lat; logic [31:0] d; logic [4:0] t; int s0;
    s0 = start_cnt;
    accept_req(2'b00, 32'd5, 32'd0, 5'd1);
    wait_resp(lat, d, t);
    total_cnt++;
    if (d !== 32'hFFFF_FFFF || lat !== 1)
      $display("FAIL div_by_zero: got %h lat %0d required ffffffff lat 1", d, lat);
    else pass_cnt++;
    accept_req(2'b10, 32'd5, 32'd0, 5'd2);
    wait_resp(lat, d, t);
    total_cnt++;
    if (d !== 32'd5 || lat !== 1)
      $display("FAIL rem_by_zero: got %h lat %0d required 00000005 lat 1", d, lat);
    else pass_cnt++;
    accept_req(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3);
    wait_resp(lat, d, t);
    total_cnt++;
    if (d !== 32'h8000_0000 || lat !== 1)
      $display("FAIL div_overflow: got %h lat %0d required 80000000 lat 1", d, lat);
    else pass_cnt++;
    accept_req(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4);
    wait_resp(lat, d, t);
    total_cnt++;
    if (d !== 32'h0 || lat !== 1)
      $display("FAIL rem_overflow: got %h lat %0d required 00000000 lat 1", d, lat);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (start_cnt !== s0) $display("FAIL special_no_start: got %0d starts required 0", start_cnt - s0);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    int lat; logic [31:0] d; logic [4:0] t;
    bus.resp_ready = 1'b0;
    accept_req(2'b01, 32'd20, 32'd6, 5'd9);
    wait_resp(lat, d, t);
    total_cnt++;
    if (d !== 32'd3 || t !== 5'd9) $display("FAIL stall_result: got %h tag %0d required 00000003 tag 9", d, t);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total_cnt++;
      if (bus.resp_valid !== 1'b1 || bus.resp_data !== 32'd3 || bus.resp_tag !== 5'd9 ||
          bus.req_ready !== 1'b0)
        $display("FAIL stall_hold_%0d: valid=%b data=%h tag=%0d req_ready=%b required 1/3/9/0",
                 i, bus.resp_valid, bus.resp_data, bus.resp_tag, bus.req_ready);
      else pass_cnt++;
    end
    bus.resp_ready = 1'b1;
    total_cnt++;
    if (bus.req_ready !== 1'b0) $display("FAIL stall_xfer_ready: got %b required 0", bus.req_ready);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1)
      $display("FAIL stall_after_xfer: valid=%b req_ready=%b required 0/1", bus.resp_valid, bus.req_ready);
    else pass_cnt++;
  endtask

  task automatic test_flush();
    int lat; logic [31:0] d; logic [4:0] t;
    int n = 0;
    bit saw_valid = 0;
    bit rdy_bad = 0;
    accept_req(2'b01, 32'd50, 32'd5, 5'd6);   // now in START
    @(posedge clk); #1;                       // now in WAIT
    flush = 1'b1;
    @(negedge clk);
    if (bus.resp_valid === 1'b1) saw_valid = 1;
    @(posedge clk); #1;
    flush = 1'b0;
    while (n < 50) begin
      @(negedge clk);
      if (bus.resp_valid === 1'b1) saw_valid = 1;
      if (div_busy !== 1'b1) break;
      if (bus.req_ready !== 1'b0) rdy_bad = 1;
      n++;
    end
    total_cnt++;
    if (n >= 50 || rdy_bad) $display("FAIL flush_drain_ready: timeout=%0d early_ready=%0d required 0/0", n >= 50, rdy_bad);
    else pass_cnt++;
    total_cnt++;
    if (bus.req_ready !== 1'b0) $display("FAIL flush_ready_at_busy_fall: got %b required 0", bus.req_ready);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (bus.req_ready !== 1'b1) $display("FAIL flush_ready_after: got %b required 1", bus.req_ready);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.resp_valid === 1'b1) saw_valid = 1;
    end
    total_cnt++;
    if (saw_valid) $display("FAIL flush_no_resp: resp_valid seen=1 required 0");
    else pass_cnt++;
    accept_req(2'b01, 32'd9, 32'd4, 5'd8);
    wait_resp(lat, d, t);
    total_cnt++;
    if (d !== 32'd2 || t !== 5'd8) $display("FAIL flush_next_divu: got %h tag %0d required 00000002 tag 8", d, t);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] d; logic [4:0] t;
    bit saw_valid = 0;
    accept_req(2'b01, 32'h0000_1000, 32'h10, 5'd3);   // START
    @(posedge clk); #1;                               // WAIT
    #2 reset = 1'b1;
    #1;
    total_cnt++;
    if (bus.resp_valid !== 1'b0 || div_start !== 1'b0 || bus.resp_data !== 32'h0 ||
        bus.resp_tag !== 5'h0 || div_dividend !== 32'h0 || div_divisor !== 32'h0)
      $display("FAIL reset_async: valid=%b start=%b data=%h tag=%h dd=%h ds=%h required all 0",
               bus.resp_valid, div_start, bus.resp_data, bus.resp_tag, div_dividend, div_divisor);
    else pass_cnt++;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.resp_valid === 1'b1) saw_valid = 1;
    end
    total_cnt++;
    if (saw_valid) $display("FAIL reset_no_resp: resp_valid seen=1 required 0");
    else pass_cnt++;
    accept_req(2'b00, 32'hFFFF_FF9C, 32'd10, 5'd12);
    wait_resp(lat, d, t);
    total_cnt++;
    if (d !== 32'hFFFF_FFF6 || t !== 5'd12)
      $display("FAIL reset_next_div: got %h tag %0d required fffffff6 tag 12", d, t);
    else pass_cnt++;
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_op     = 2'b00;
    bus.req_rs1    = '0;
    bus.req_rs2    = '0;
    bus.req_tag    = '0;
    bus.resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    test_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    test_signed();
    test_unsigned();
    test_special();
    test_stall();
    test_flush();
    test_reset_mid();
    total_cnt++;
    if (start_while_busy !== 0) $display("FAIL start_while_busy: got %0d required 0", start_while_busy);
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
